// File: rtl/led_status_ctrl.sv
// Per-channel LED status driver: static, blink, pulse-stretch and PWM-dim modes
// selectable per channel, with an all-on lamp test after every reset.
// Every output is registered, so no input reaches led or lamp_test_busy combinationally.
module led_status_ctrl #(
   parameter int NUM_LED    = 8,
   parameter int PRESCALE   = 1000000,
   parameter int LAMP_TICKS = 2,
   parameter int STRETCH    = 3,
   parameter int PWM_W      = 4,
   localparam int IDX_W     = (NUM_LED > 1) ? $clog2(NUM_LED) : 1
) (
   input  logic               sys0_clk,
   input  logic               sys0_rst,
   input  logic               cfg_we,
   input  logic [IDX_W-1:0]   cfg_idx,
   input  logic [1:0]         cfg_mode,
   input  logic [PWM_W-1:0]   cfg_duty,
   input  logic [NUM_LED-1:0] led_in,
   output logic [NUM_LED-1:0] led,
   output logic               lamp_test_busy
);

   localparam int PRE_W = $clog2(PRESCALE);
   localparam int LT_W  = $clog2(LAMP_TICKS + 1);
   localparam int ST_W  = $clog2(STRETCH + 1);

   typedef enum logic {ST_LAMP, ST_RUN} state_t;

   state_t             state_reg;
   logic [PRE_W-1:0]   pre_cnt_reg;
   logic [LT_W-1:0]    lamp_cnt_reg;
   logic               blink_phase_reg;
   logic [PWM_W-1:0]   pwm_cnt_reg;
   logic [NUM_LED-1:0] led_reg;
   logic               busy_reg;
   logic               tick;
   logic [NUM_LED-1:0] run_led;

   // tick is a one-cycle strobe on the last count of each prescaler period
   assign tick = (pre_cnt_reg == PRE_W'(PRESCALE - 1));

   // Prescaler: 0..PRESCALE-1, wrapping
   always_ff @(posedge sys0_clk) begin
      if (sys0_rst)
         pre_cnt_reg <= '0;
      else if (tick)
         pre_cnt_reg <= '0;
      else
         pre_cnt_reg <= pre_cnt_reg + PRE_W'(1);
   end

   // Shared blink phase toggles on every tick, including during the lamp test
   always_ff @(posedge sys0_clk) begin
      if (sys0_rst)
         blink_phase_reg <= 1'b0;
      else if (tick)
         blink_phase_reg <= ~blink_phase_reg;
   end

   // Free-running PWM counter shared by all dimmed channels
   always_ff @(posedge sys0_clk) begin
      if (sys0_rst)
         pwm_cnt_reg <= '0;
      else
         pwm_cnt_reg <= pwm_cnt_reg + PWM_W'(1);
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_LED; gi++) begin : g_ch
         logic [1:0]       mode_reg;
         logic [PWM_W-1:0] duty_reg;
         logic [ST_W-1:0]  str_cnt_reg;
         logic             sel;
         logic             chan_led;

         // Out-of-range indices match no channel, so they are silently dropped
         assign sel = cfg_we && (int'(cfg_idx) == gi);

         // Channel configuration store
         always_ff @(posedge sys0_clk) begin
            if (sys0_rst) begin
               mode_reg <= 2'b00;
               duty_reg <= '0;
            end else if (sel) begin
               mode_reg <= cfg_mode;
               duty_reg <= cfg_duty;
            end
         end

         // Stretch counter runs in every mode; a new event reload beats the tick decrement
         always_ff @(posedge sys0_clk) begin
            if (sys0_rst)
               str_cnt_reg <= '0;
            else if (led_in[gi])
               str_cnt_reg <= ST_W'(STRETCH);
            else if (tick && (str_cnt_reg != '0))
               str_cnt_reg <= str_cnt_reg - ST_W'(1);
         end

         // Per-mode LED value, registered by the FSM below
         always_comb begin
            chan_led = 1'b0;
            case (mode_reg)
               2'b00:   chan_led = led_in[gi];
               2'b01:   chan_led = blink_phase_reg;
               2'b10:   chan_led = led_in[gi] | (str_cnt_reg != '0);
               default: chan_led = (duty_reg == '1) || (pwm_cnt_reg < duty_reg);
            endcase
         end

         assign run_led[gi] = chan_led;
      end
   endgenerate

   // Lamp-test / run FSM with registered led and busy outputs
   always_ff @(posedge sys0_clk) begin
      if (sys0_rst) begin
         state_reg    <= ST_LAMP;
         lamp_cnt_reg <= '0;
         led_reg      <= '0;
         busy_reg     <= 1'b1;
      end else begin
         case (state_reg)
            ST_LAMP: begin
               led_reg <= '1;
               if (tick) begin
                  if (lamp_cnt_reg == LT_W'(LAMP_TICKS - 1)) begin
                     // Leave the lamp test: busy drops and normal drive starts on the same edge
                     state_reg <= ST_RUN;
                     busy_reg  <= 1'b0;
                     led_reg   <= run_led;
                  end else begin
                     lamp_cnt_reg <= lamp_cnt_reg + LT_W'(1);
                  end
               end
            end
            ST_RUN: begin
               led_reg <= run_led;
            end
            default: begin
               state_reg <= ST_LAMP;
            end
         endcase
      end
   end

   assign led            = led_reg;
   assign lamp_test_busy = busy_reg;

endmodule

// File: tb/tb_led_status_ctrl.sv
// Randomised bench for led_status_ctrl. The reference model derives every LED value from
// the number of clock edges since reset (tick count, blink phase, PWM count, time since the
// last event) rather than tracking the design's counters.
module tb_led_status_ctrl;

   localparam int P  = 4;
   localparam int LT = 2;
   localparam int ST = 3;
   localparam int PW = 2;
   localparam int N  = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cfg_we = 1'b0;
   logic [2:0] cfg_idx = '0;
   logic [1:0] cfg_mode = '0;
   logic [1:0] cfg_duty = '0;
   logic [7:0] led_in = '0;
   logic [7:0] led;
   logic       busy;
   logic [5:0] led6;
   logic       busy6;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   led_status_ctrl #(.NUM_LED(N), .PRESCALE(P), .LAMP_TICKS(LT), .STRETCH(ST), .PWM_W(PW)) u_dut (
      .sys0_clk(clk), .sys0_rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_mode(cfg_mode),
      .cfg_duty(cfg_duty), .led_in(led_in), .led(led), .lamp_test_busy(busy));

   // Six-channel instance sharing all inputs: indices 6 and 7 must be ignored there
   led_status_ctrl #(.NUM_LED(6), .PRESCALE(P), .LAMP_TICKS(LT), .STRETCH(ST), .PWM_W(PW)) u_dut6 (
      .sys0_clk(clk), .sys0_rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_mode(cfg_mode),
      .cfg_duty(cfg_duty), .led_in(led_in[5:0]), .led(led6), .lamp_test_busy(busy6));

   // ---------------- reference model ----------------
   int         e = 0;
   logic [7:0] exp_led = '0;
   logic       exp_busy = 1'b1;
   logic [1:0] mode_m [N];
   logic [1:0] duty_m [N];
   int         last_ev [N];

   always @(posedge clk) begin
      logic [7:0] run;
      int pend;
      run = '0;
      if (rst) begin
         e = 0;
         exp_led = '0;
         exp_busy = 1'b1;
         for (int i = 0; i < N; i++) begin
            mode_m[i] = 2'b00;
            duty_m[i] = 2'b00;
            last_ev[i] = -1;
         end
      end else begin
         e = e + 1;
         for (int i = 0; i < N; i++) begin
            // events still pending = STRETCH minus ticks seen strictly after the last event
            if (last_ev[i] < 0) pend = 0;
            else pend = ST - ((e - 1) / P - last_ev[i] / P);
            if (pend < 0) pend = 0;
            case (mode_m[i])
               2'd0: run[i] = led_in[i];
               2'd1: run[i] = (((e - 1) / P) % 2) == 1;
               2'd2: run[i] = led_in[i] || (pend > 0);
               default: run[i] = (duty_m[i] == 2'd3) || (((e - 1) % (1 << PW)) < int'(duty_m[i]));
            endcase
            if (led_in[i]) last_ev[i] = e;
         end
         exp_busy = (e < P * LT);
         exp_led  = exp_busy ? 8'hFF : run;
         if (cfg_we && int'(cfg_idx) < N) begin
            mode_m[cfg_idx] = cfg_mode;
            duty_m[cfg_idx] = cfg_duty;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cfg_write(input int idx, input int mode, input int duty);
      cfg_we   = 1'b1;
      cfg_idx  = 3'(idx);
      cfg_mode = 2'(mode);
      cfg_duty = 2'(duty);
      $display("cfg write: idx=%0d mode=%0d duty=%0d", idx, mode, duty);
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   // ---------------- scenario tasks ----------------
   task automatic test_reset();
      rst = 1'b1;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         checks++;
         if (led !== 8'h00) begin errors++; $display("FAIL reset_led: got %h want 00", led); end
         checks++;
         if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", busy); end
         checks++;
         if (led6 !== 6'h00 || busy6 !== 1'b1) begin
            errors++; $display("FAIL reset_dut6: got led=%h busy=%b want 00/1", led6, busy6);
         end
      end
      $display("reset held, checked led/busy");
   endtask

   task automatic test_lamp();
      int busy_cycles = 0;
      rst = 1'b0;
      led_in = 8'h00;
      for (int n = 0; n < 14; n++) begin
         @(negedge clk);
         if (busy === 1'b1) busy_cycles++;
         checks++;
         if (led !== exp_led) begin errors++; $display("FAIL lamp_led: cyc %0d got %h want %h", n, led, exp_led); end
         checks++;
         if (busy !== exp_busy) begin errors++; $display("FAIL lamp_busy: cyc %0d got %b want %b", n, busy, exp_busy); end
         checks++;
         if (led6 !== exp_led[5:0] || busy6 !== exp_busy) begin
            errors++; $display("FAIL lamp_dut6: cyc %0d got %h/%b want %h/%b", n, led6, busy6, exp_led[5:0], exp_busy);
         end
      end
      // after release, busy stays high until the LAMP_TICKS-th tick edge
      checks++;
      if (busy_cycles != P * LT - 1) begin
         errors++; $display("FAIL lamp_length: busy cycles %0d want %0d", busy_cycles, P * LT - 1);
      end
      $display("lamp test done, busy for %0d cycles after release", busy_cycles);
   endtask

   task automatic test_static();
      for (int n = 0; n < 20; n++) begin
         led_in = (n == 0) ? 8'hA5 : (n == 1) ? 8'h00 : 8'($urandom);
         @(negedge clk);
         checks++;
         if (led !== exp_led) begin errors++; $display("FAIL static_led: cyc %0d got %h want %h", n, led, exp_led); end
         checks++;
         if (led6 !== exp_led[5:0]) begin errors++; $display("FAIL static_dut6: cyc %0d got %h want %h", n, led6, exp_led[5:0]); end
      end
      $display("static mode: 20 cycles checked");
   endtask

   task automatic test_blink();
      cfg_write(0, 1, 0);
      for (int n = 0; n < 24; n++) begin
         led_in = 8'($urandom) & 8'hFE;
         @(negedge clk);
         checks++;
         if (led !== exp_led) begin errors++; $display("FAIL blink_led: cyc %0d got %h want %h", n, led, exp_led); end
      end
      $display("blink mode on ch0: 24 cycles checked");
   endtask

   task automatic test_stretch();
      cfg_write(1, 2, 0);
      for (int n = 0; n < 80; n++) begin
         led_in = {6'($urandom) & 6'h3C, ($urandom_range(0, 5) == 0), 1'b0};
         @(negedge clk);
         checks++;
         if (led !== exp_led) begin errors++; $display("FAIL stretch_led: cyc %0d got %h want %h", n, led, exp_led); end
      end
      led_in = 8'h00;
      $display("stretch mode on ch1: 80 cycles checked");
   endtask

   task automatic test_pwm();
      int duties [4] = '{1, 3, 0, 2};
      for (int d = 0; d < 4; d++) begin
         cfg_write(2, 3, duties[d]);
         for (int n = 0; n < 12; n++) begin
            led_in = 8'($urandom) & 8'hF8;
            @(negedge clk);
            checks++;
            if (led !== exp_led) begin
               errors++; $display("FAIL pwm_led: duty %0d cyc %0d got %h want %h", duties[d], n, led, exp_led);
            end
         end
      end
      $display("pwm mode on ch2: duties 1,3,0,2 checked");
   endtask

   task automatic test_random_cfg();
      for (int n = 0; n < 300; n++) begin
         led_in = 8'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            cfg_we   = 1'b1;
            cfg_idx  = 3'($urandom);
            cfg_mode = 2'($urandom);
            cfg_duty = 2'($urandom);
         end else begin
            cfg_we = 1'b0;
         end
         @(negedge clk);
         checks++;
         if (led !== exp_led) begin errors++; $display("FAIL random_led: cyc %0d got %h want %h", n, led, exp_led); end
         checks++;
         if (led6 !== exp_led[5:0]) begin errors++; $display("FAIL random_dut6: cyc %0d got %h want %h", n, led6, exp_led[5:0]); end
      end
      cfg_we = 1'b0;
      $display("random config/input traffic: 300 cycles checked");
   endtask

   task automatic test_mid_reset();
      // load stretch and PWM activity, then reset in the middle of it
      cfg_write(1, 2, 0);
      cfg_write(7, 3, 1);
      led_in = 8'h02;
      @(negedge clk);
      led_in = 8'h00;
      @(negedge clk);
      rst = 1'b1;
      for (int n = 0; n < 2; n++) begin
         @(negedge clk);
         checks++;
         if (led !== 8'h00 || busy !== 1'b1) begin
            errors++; $display("FAIL midreset_hold: got %h/%b want 00/1", led, busy);
         end
      end
      rst = 1'b0;
      for (int n = 0; n < 30; n++) begin
         led_in = 8'($urandom);
         @(negedge clk);
         checks++;
         if (led !== exp_led) begin errors++; $display("FAIL midreset_led: cyc %0d got %h want %h", n, led, exp_led); end
         checks++;
         if (busy !== exp_busy) begin errors++; $display("FAIL midreset_busy: cyc %0d got %b want %b", n, busy, exp_busy); end
      end
      $display("mid-operation reset: lamp rerun and static modes checked");
   endtask

   task automatic test_idx_range();
      // idx 7 is valid for 8 channels, beyond range for the 6-channel instance
      cfg_write(7, 1, 2);
      cfg_write(6, 3, 3);
      for (int n = 0; n < 20; n++) begin
         led_in = 8'($urandom);
         @(negedge clk);
         checks++;
         if (led !== exp_led) begin errors++; $display("FAIL idx_led: cyc %0d got %h want %h", n, led, exp_led); end
         checks++;
         if (led6 !== led_in_prev6()) begin errors++; $display("FAIL idx_dut6: cyc %0d got %h want %h", n, led6, led_in_prev6()); end
      end
      $display("out-of-range cfg_idx on 6-channel instance checked");
   endtask

   // After a reset with no in-range writes the 6-channel instance is fully static
   logic [5:0] prev_in6 = '0;
   always @(posedge clk) prev_in6 <= led_in[5:0];
   function automatic logic [5:0] led_in_prev6();
      return prev_in6;
   endfunction

   initial begin
      test_reset();
      test_lamp();
      test_static();
      test_blink();
      test_stretch();
      test_pwm();
      test_random_cfg();
      test_mid_reset();
      test_idx_range();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
